// File: rtl/td4_load_run_ctrl.sv
// Load/run sequencer for the TD4 4-bit CPU: byte-serial program load with
// checksum, then free-run / single-step / breakpoint control via cpu_ce.
module td4_load_run_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic [7:0] ld_sum,
  input  logic       run,
  input  logic       step,
  input  logic       bp_en,
  input  logic [3:0] bp_addr,
  input  logic [3:0] pc,
  output logic [7:0] mem0,
  output logic [7:0] mem1,
  output logic [7:0] mem2,
  output logic [7:0] mem3,
  output logic [7:0] mem4,
  output logic [7:0] mem5,
  output logic [7:0] mem6,
  output logic [7:0] mem7,
  output logic [7:0] mem8,
  output logic [7:0] mem9,
  output logic [7:0] memA,
  output logic [7:0] memB,
  output logic [7:0] memC,
  output logic [7:0] memD,
  output logic [7:0] memE,
  output logic [7:0] memF,
  output logic       cpu_rst_n,
  output logic       cpu_ce,
  output logic [2:0] state,
  output logic       load_err,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_CHECK = 3'b010,
    S_PAUSE = 3'b011,
    S_RUN   = 3'b100,
    S_HALT  = 3'b101
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] addr_q;
  logic [7:0] sum_q;
  logic       step_q;
  logic       ld_ready_q;
  logic       load_err_q;
  logic [7:0] cnt_q;
  logic [7:0] mem_q [16];

  logic       load_go;
  logic       step_go;
  logic       restart;
  logic       beat;
  logic       wr_en;
  logic       bp_hit;

  // Load link: a byte transfers on a rising edge where ld_valid & ld_ready.
  // ld_ready depends only on state; a beat coinciding with ld_start is dropped.
  assign beat    = ld_valid & ld_ready_q;
  assign restart = (state_q == S_LOAD) & ld_start;
  assign wr_en   = (state_q == S_LOAD) & beat & ~ld_start;
  assign bp_hit  = bp_en & (pc == bp_addr);

  always_comb begin
    state_d = state_q;
    load_go = 1'b0;
    step_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d = S_LOAD;
          load_go = 1'b1;
        end
      end
      S_LOAD: begin
        if (wr_en && addr_q == 4'hF) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = (sum_q == ld_sum) ? S_PAUSE : S_IDLE;
      end
      S_PAUSE: begin
        if (ld_start) begin
          state_d = S_LOAD;
          load_go = 1'b1;
        end else if (step && !step_q) begin
          step_go = 1'b1;
        end else if (run && !step_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ld_start) begin
          state_d = S_LOAD;
          load_go = 1'b1;
        end else if (bp_hit) begin
          state_d = S_HALT;
        end else if (!run) begin
          state_d = S_PAUSE;
        end
      end
      S_HALT: begin
        if (ld_start) begin
          state_d = S_LOAD;
          load_go = 1'b1;
        end else if (step && !step_q) begin
          step_go = 1'b1;
          state_d = S_PAUSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      addr_q     <= 4'h0;
      sum_q      <= 8'h00;
      step_q     <= 1'b0;
      ld_ready_q <= 1'b0;
      load_err_q <= 1'b0;
      cnt_q      <= 8'h00;
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= (state_d == S_LOAD);
      step_q     <= step_go;

      if (load_go || restart) begin
        addr_q <= 4'h0;
        sum_q  <= 8'h00;
      end else if (wr_en) begin
        mem_q[addr_q] <= ld_data;
        sum_q         <= sum_q + ld_data;
        addr_q        <= addr_q + 4'd1;
      end

      if (load_go)
        load_err_q <= 1'b0;
      else if (state_q == S_CHECK && sum_q != ld_sum)
        load_err_q <= 1'b1;

      if (load_go)
        cnt_q <= 8'h00;
      else if (cpu_ce && cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  // The instruction at bp_addr is withheld in the very cycle pc reaches it.
  assign cpu_ce    = ((state_q == S_RUN) & ~bp_hit) | step_q;
  assign cpu_rst_n = (state_q == S_PAUSE) | (state_q == S_RUN) | (state_q == S_HALT);
  assign state     = state_q;
  assign ld_ready  = ld_ready_q;
  assign load_err  = load_err_q;
  assign cycle_cnt = cnt_q;

  assign mem0 = mem_q[0];
  assign mem1 = mem_q[1];
  assign mem2 = mem_q[2];
  assign mem3 = mem_q[3];
  assign mem4 = mem_q[4];
  assign mem5 = mem_q[5];
  assign mem6 = mem_q[6];
  assign mem7 = mem_q[7];
  assign mem8 = mem_q[8];
  assign mem9 = mem_q[9];
  assign memA = mem_q[10];
  assign memB = mem_q[11];
  assign memC = mem_q[12];
  assign memD = mem_q[13];
  assign memE = mem_q[14];
  assign memF = mem_q[15];

endmodule

// File: tb/tb_td4_load_run_ctrl.sv
// Directed bench for td4_load_run_ctrl: load/checksum, restart, step,
// breakpoint halt/resume, counter saturation and asynchronous reset.
module tb_td4_load_run_ctrl;

  logic       CLK;
  logic       RST;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic [7:0] ld_sum;
  logic       run;
  logic       step;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic [3:0] pc;
  logic [7:0] mem0, mem1, mem2, mem3, mem4, mem5, mem6, mem7;
  logic [7:0] mem8, mem9, memA, memB, memC, memD, memE, memF;
  logic       cpu_rst_n;
  logic       cpu_ce;
  logic [2:0] state;
  logic       load_err;
  logic [7:0] cycle_cnt;

  logic [7:0] mem_o [16];
  logic [7:0] exp_q [$];
  int checks;
  int errors;

  td4_load_run_ctrl dut (
    .CLK(CLK), .RST(RST),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_sum(ld_sum),
    .run(run), .step(step), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3),
    .mem4(mem4), .mem5(mem5), .mem6(mem6), .mem7(mem7),
    .mem8(mem8), .mem9(mem9), .memA(memA), .memB(memB),
    .memC(memC), .memD(memD), .memE(memE), .memF(memF),
    .cpu_rst_n(cpu_rst_n), .cpu_ce(cpu_ce), .state(state),
    .load_err(load_err), .cycle_cnt(cycle_cnt)
  );

  assign mem_o[0]  = mem0;
  assign mem_o[1]  = mem1;
  assign mem_o[2]  = mem2;
  assign mem_o[3]  = mem3;
  assign mem_o[4]  = mem4;
  assign mem_o[5]  = mem5;
  assign mem_o[6]  = mem6;
  assign mem_o[7]  = mem7;
  assign mem_o[8]  = mem8;
  assign mem_o[9]  = mem9;
  assign mem_o[10] = memA;
  assign mem_o[11] = memB;
  assign mem_o[12] = memC;
  assign mem_o[13] = memD;
  assign mem_o[14] = memE;
  assign mem_o[15] = memF;

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic load_b2b(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_queue observed=empty expected=byte%0d", tag, i);
      end else begin
        chk(tag, {24'h0, mem_o[i]}, {24'h0, exp_q.pop_front()});
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RST      = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    ld_sum   = 8'h00;
    run      = 1'b0;
    step     = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 4'h0;
    pc       = 4'h0;
    tick();
    tick();

    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_memF", 32'(memF), 32'd0);
    RST = 1'b1;
    tick();

    // good load: 0x01..0x10 sums to 0x88
    ld_sum = 8'h88;
    pulse_start();
    chk("t1_state_load", 32'(state), 32'd1);
    chk("t1_ld_ready", 32'(ld_ready), 32'd1);
    load_b2b(8'h01);
    chk("t1_state_check", 32'(state), 32'd2);
    chk("t1_ld_ready_drop", 32'(ld_ready), 32'd0);
    tick();
    chk("t1_state_pause", 32'(state), 32'd3);
    chk("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("t1_load_err", 32'(load_err), 32'd0);
    chk("t1_cpu_ce", 32'(cpu_ce), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
    check_mem("t1_mem");

    // bad checksum from PAUSE
    ld_sum = 8'h00;
    pulse_start();
    chk("t2_state_load", 32'(state), 32'd1);
    chk("t2_cpu_rst_n_drop", 32'(cpu_rst_n), 32'd0);
    load_b2b(8'h01);
    tick();
    chk("t2_state_idle", 32'(state), 32'd0);
    chk("t2_load_err", 32'(load_err), 32'd1);
    chk("t2_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    pulse_start();
    chk("t2_load_err_clr", 32'(load_err), 32'd0);
    chk("t2_state_load2", 32'(state), 32'd1);

    // toggling valid, restart after 5 beats; 0xB0..0xBF sums to 0x78
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'hA0 + 8'(i);
      tick();
      ld_valid = 1'b0;
      tick();
    end
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk("t3_restart_state", 32'(state), 32'd1);
    chk("t3_mem0_kept", 32'(mem0), 32'hA0);
    ld_sum = 8'h78;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'hB0 + 8'(i);
      tick();
      ld_valid = 1'b0;
      if (i == 14) chk("t3_still_load", 32'(state), 32'd1);
      if (i == 15) chk("t3_state_check", 32'(state), 32'd2);
      else tick();
    end
    tick();
    chk("t3_state_pause", 32'(state), 32'd3);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hB0 + 8'(i));
    check_mem("t3_mem");

    // single step in PAUSE, second step during step_q ignored
    chk("t4_cnt_start", 32'(cycle_cnt), 32'd0);
    step = 1'b1;
    tick();
    chk("t4_ce_on", 32'(cpu_ce), 32'd1);
    chk("t4_state_pause", 32'(state), 32'd3);
    tick();
    step = 1'b0;
    chk("t4_ce_off", 32'(cpu_ce), 32'd0);
    chk("t4_cnt_one", 32'(cycle_cnt), 32'd1);
    tick();
    chk("t4_ce_still_off", 32'(cpu_ce), 32'd0);
    chk("t4_cnt_hold", 32'(cycle_cnt), 32'd1);

    // breakpoint at 0x3, halt, step-resume, re-enter RUN
    bp_en   = 1'b1;
    bp_addr = 4'h3;
    pc      = 4'h0;
    run     = 1'b1;
    tick();
    chk("t5_state_run", 32'(state), 32'd4);
    chk("t5_ce_run", 32'(cpu_ce), 32'd1);
    for (int p = 1; p < 4; p++) begin
      tick();
      pc = 4'(p);
    end
    #1;
    chk("t5_ce_bp", 32'(cpu_ce), 32'd0);
    chk("t5_state_run_bp", 32'(state), 32'd4);
    tick();
    chk("t5_state_halt", 32'(state), 32'd5);
    chk("t5_cnt_halt", 32'(cycle_cnt), 32'd4);
    tick();
    chk("t5_halt_hold", 32'(state), 32'd5);
    chk("t5_halt_ce", 32'(cpu_ce), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("t5_step_state", 32'(state), 32'd3);
    chk("t5_step_ce", 32'(cpu_ce), 32'd1);
    tick();
    pc = 4'h4;
    chk("t5_pause_state", 32'(state), 32'd3);
    chk("t5_pause_ce", 32'(cpu_ce), 32'd0);
    chk("t5_cnt_step", 32'(cycle_cnt), 32'd5);
    tick();
    chk("t5_rerun_state", 32'(state), 32'd4);
    chk("t5_rerun_ce", 32'(cpu_ce), 32'd1);

    // saturation, then asynchronous reset mid-run
    bp_en = 1'b0;
    repeat (300) tick();
    chk("t6_cnt_sat", 32'(cycle_cnt), 32'd255);
    chk("t6_state_run", 32'(state), 32'd4);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("t6_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("t6_rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("t6_rst_load_err", 32'(load_err), 32'd0);
    chk("t6_rst_cnt", 32'(cycle_cnt), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
    check_mem("t6_rst_mem");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
